// File: rtl/rv_fifo.sv
// rv_fifo: first-word-fall-through FIFO with ready/valid on both ends.
// Optional feature macro: RV_FIFO_OCCUPANCY_EN adds a registered occupancy count port.
// Full/empty come from extended pointers; the storage array itself is never reset.
module rv_fifo #(
  parameter int WIDTH    = 32,
  parameter int LOGDEPTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enq_valid,
  input  logic [WIDTH-1:0]    enq_data,
  output logic                enq_ready,
  output logic                deq_valid,
  output logic [WIDTH-1:0]    deq_data,
`ifdef RV_FIFO_OCCUPANCY_EN
  output logic [LOGDEPTH:0]   occupancy,
`endif
  input  logic                deq_ready
);

  localparam int DEPTH = 1 << LOGDEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOGDEPTH:0] wr_ptr, rd_ptr;
  logic full, empty, wr_fire, rd_fire;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOGDEPTH-1:0] == rd_ptr[LOGDEPTH-1:0]) &&
                 (wr_ptr[LOGDEPTH] != rd_ptr[LOGDEPTH]);

  assign enq_ready = !full;
  assign deq_valid = !empty;
  assign wr_fire   = enq_valid && enq_ready;
  assign rd_fire   = deq_valid && deq_ready;

  // Head entry is driven straight from storage; masked to zero when empty.
  assign deq_data = deq_valid ? mem[rd_ptr[LOGDEPTH-1:0]] : '0;

  // Pointer update; both may advance on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are left untouched by reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[LOGDEPTH-1:0]] <= enq_data;
  end

`ifdef RV_FIFO_OCCUPANCY_EN
  // Entry count tracks write-only / read-only transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case ({wr_fire, rd_fire})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end
`endif

endmodule
